// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters the pins, deserialises 11-bit frames,
// strips E0/F0/E1 prefixes and emits make/release scancode pulses.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key_in,
  output logic       key_en,
  output logic       key_rel,
  output logic       key_ext,
  output logic       err_parity,
  output logic       err_frame,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt, clk_flt_d;
  logic          strobe, dat;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync  <= 2'b00;
      dat_sync  <= 2'b00;
      flt_cnt   <= '0;
      clk_flt   <= 1'b1;
      clk_flt_d <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_dat};
      clk_flt_d <= clk_flt;
      // Any sample matching the current level restarts the run count.
      if (clk_sync[1] == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_flt <= clk_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign strobe = clk_flt_d & ~clk_flt;
  assign dat    = dat_sync[1];

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          par_bit, par_nxt;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          vld_nxt, perr_nxt, ferr_nxt, drop;
  logic          byte_vld;
  logic [7:0]    byte_q;

  assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    par_nxt   = par_bit;
    vld_nxt   = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    drop      = 1'b0;
    if (strobe) begin
      case (state)
        IDLE: if (!dat) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
        end
        DATA: begin
          sh_nxt  = {dat, shreg[7:1]};
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = dat;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (!dat) begin
            ferr_nxt = 1'b1;
            drop     = 1'b1;
          end else if (!(^{shreg, par_bit})) begin
            perr_nxt = 1'b1;
            drop     = 1'b1;
          end else begin
            vld_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
      ferr_nxt  = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      byte_vld   <= 1'b0;
      byte_q     <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= sh_nxt;
      par_bit    <= par_nxt;
      byte_vld   <= vld_nxt;
      byte_q     <= shreg;
      err_parity <= perr_nxt;
      err_frame  <= ferr_nxt;
      if (strobe || state == IDLE) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Prefix / pause-sequence decode of each accepted byte.
  logic       ext_pend, brk_pend;
  logic [2:0] skip_cnt;
  logic       is_status;

  always_comb begin
    is_status = 1'b0;
    case (byte_q)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_status = 1'b1;
      default: is_status = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      skip_cnt <= '0;
      key_in   <= '0;
      key_ext  <= 1'b0;
      key_en   <= 1'b0;
      key_rel  <= 1'b0;
    end else begin
      key_en  <= 1'b0;
      key_rel <= 1'b0;
      if (drop) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
        skip_cnt <= '0;
      end else if (timeout && !strobe) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_vld) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (byte_q == 8'hE1) begin
          skip_cnt <= 3'd7;
        end else if (byte_q == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (!(is_status && !ext_pend && !brk_pend)) begin
          key_in   <= byte_q;
          key_ext  <= ext_pend;
          key_en   <= ~brk_pend;
          key_rel  <= brk_pend;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-bangs PS/2 frames and checks pulses and codes.
module tb_ps2_scancode_rx;
  localparam int HALF = 40;

  logic       iCLK = 1'b0;
  logic       iRST_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key_in;
  logic       key_en, key_rel, key_ext, err_parity, err_frame, busy;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT(400)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .key_in(key_in), .key_en(key_en), .key_rel(key_rel), .key_ext(key_ext),
    .err_parity(err_parity), .err_frame(err_frame), .busy(busy)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int n_en = 0, n_rel = 0, n_perr = 0, n_ferr = 0;
  int en_cyc = 0, stop_cyc = 0;
  bit busy_seen = 1'b0;

  // Pulse monitor; every sampled high cycle counts, so a stretched pulse over-counts.
  always @(negedge iCLK) begin
    if (key_en)     begin n_en++; en_cyc = cyc; end
    if (key_rel)    n_rel++;
    if (err_parity) n_perr++;
    if (err_frame)  n_ferr++;
    if (busy)       busy_seen = 1'b1;
    if (key_en | key_rel | err_parity | err_frame) begin
      checks++;
      assert ($countones({key_en, key_rel, err_parity, err_frame}) == 1)
      else begin
        errors++;
        $error("FAIL onehot: observed %b expected one bit", {key_en, key_rel, err_parity, err_frame});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic clr();
    n_en = 0; n_rel = 0; n_perr = 0; n_ferr = 0; busy_seen = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    stop_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    wait_cyc(60);
  endtask

  task automatic partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(i[0]);
    ps2_dat = 1'b1;
  endtask

  initial begin
    wait_cyc(5);
    iRST_n = 1'b1;
    wait_cyc(20);
    chk("reset_key_in", key_in, 8'h00);
    chk("reset_flags", {key_en, key_rel, key_ext, err_parity, err_frame, busy}, 6'b0);

    // Plain make code; stop falls at cycle n, pulse expected at n+12.
    clr();
    send(8'h1C, 1'b0, 1'b0);
    chk("1c_en_cnt", n_en, 1);
    chk("1c_rel_cnt", n_rel, 0);
    chk("1c_key", key_in, 8'h1C);
    chk("1c_ext", key_ext, 1'b0);
    chk("1c_latency", en_cyc - stop_cyc, 12);

    // Extended make, then extended break.
    clr();
    send(8'hE0, 1'b0, 1'b0);
    chk("e0_quiet", n_en + n_rel + n_perr + n_ferr, 0);
    send(8'h6B, 1'b0, 1'b0);
    chk("6b_en_cnt", n_en, 1);
    chk("6b_key", key_in, 8'h6B);
    chk("6b_ext", key_ext, 1'b1);
    clr();
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h74, 1'b0, 1'b0);
    chk("74_rel_cnt", n_rel, 1);
    chk("74_en_cnt", n_en, 0);
    chk("74_key", key_in, 8'h74);
    chk("74_ext", key_ext, 1'b1);

    // Parity error keeps the previous code.
    clr();
    send(8'h1C, 1'b1, 1'b0);
    chk("perr_cnt", n_perr, 1);
    chk("perr_en_cnt", n_en, 0);
    chk("perr_key_held", key_in, 8'h74);
    send(8'h1B, 1'b0, 1'b0);
    chk("1b_en_cnt", n_en, 1);
    chk("1b_key", key_in, 8'h1B);
    chk("1b_ext", key_ext, 1'b0);

    // Timeout abort of a partial frame.
    clr();
    partial(4);
    wait_cyc(5);
    chk("to_busy_mid", busy, 1'b1);
    wait_cyc(450);
    chk("to_ferr_cnt", n_ferr, 1);
    chk("to_busy_after", busy, 1'b0);
    send(8'h29, 1'b0, 1'b0);
    chk("29_en_cnt", n_en, 1);
    chk("29_key", key_in, 8'h29);

    // Clock glitches shorter than the filter.
    clr();
    ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(30);
    ps2_clk = 1'b0; wait_cyc(7); ps2_clk = 1'b1; wait_cyc(30);
    chk("glitch_busy", busy_seen, 1'b0);
    chk("glitch_ferr", n_ferr, 0);

    // Bad stop bit.
    send(8'h1C, 1'b0, 1'b1);
    chk("stop_ferr_cnt", n_ferr, 1);
    chk("stop_en_cnt", n_en, 0);

    // Pause sequence swallowed, following key emitted.
    clr();
    send(8'hE1, 1'b0, 1'b0);
    send(8'h14, 1'b0, 1'b0);
    send(8'h77, 1'b0, 1'b0);
    send(8'hE1, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h14, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h77, 1'b0, 1'b0);
    chk("pause_quiet", n_en + n_rel, 0);
    send(8'h1C, 1'b0, 1'b0);
    chk("pause_en_cnt", n_en, 1);
    chk("pause_rel_cnt", n_rel, 0);
    chk("pause_key", key_in, 8'h1C);

    // Asynchronous reset mid-frame.
    partial(5);
    wait_cyc(1);
    chk("prerst_busy", busy, 1'b1);
    iRST_n = 1'b0;
    #1;
    chk("rst_key_in", key_in, 8'h00);
    chk("rst_flags", {key_en, key_rel, key_ext, err_parity, err_frame, busy}, 6'b0);
    wait_cyc(3);
    iRST_n = 1'b1;
    wait_cyc(20);
    clr();
    send(8'h5A, 1'b0, 1'b0);
    chk("5a_en_cnt", n_en, 1);
    chk("5a_key", key_in, 8'h5A);

    // Typematic repeat of the same code.
    send(8'h5A, 1'b0, 1'b0);
    chk("repeat_en_cnt", n_en, 2);
    chk("repeat_err_cnt", n_perr + n_ferr + n_rel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
